mem_wb_pipe_stage: RTL

MEM_WB_PIPE_STAGE -- requirements
Module: mem_wb_pipe_stage

---
 rtl/mem_wb_pipe_stage_pkg.sv | 14 +
 rtl/mem_wb_pipe_stage_if.sv | 27 ++
 rtl/mem_wb_pipe_stage_pipe_slot.sv | 43 ++++
 rtl/mem_wb_pipe_stage.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mem_wb_pipe_stage_pkg.sv
// Shared MEM/WB pipeline definitions: occupancy states and default widths.
package mem_wb_pipe_stage_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_RD_W   = 5;
    localparam int unsigned DEF_CNT_W  = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/mem_wb_pipe_stage_if.sv
// Valid/ready pipeline link carrying one MEM/WB entry; master drives the entry.
interface mem_wb_pipe_stage_if
    import mem_wb_pipe_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_W   = DEF_RD_W
) ();

    logic              valid;
    logic              ready;
    logic              regwrite;
    logic              memtoreg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu;
    logic [RD_W-1:0]   rd;

    modport master (
        output valid, regwrite, memtoreg, read_data, alu, rd,
        input  ready
    );

    modport slave (
        input  valid, regwrite, memtoreg, read_data, alu, rd,
        output ready
    );

endinterface

// File: rtl/mem_wb_pipe_stage_pipe_slot.sv
// One pipeline entry register; clear drops only the control bits, data holds.
module pipe_slot
    import mem_wb_pipe_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_W   = DEF_RD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              d_regwrite,
    input  logic              d_memtoreg,
    input  logic [DATA_W-1:0] d_read_data,
    input  logic [DATA_W-1:0] d_alu,
    input  logic [RD_W-1:0]   d_rd,
    output logic              q_regwrite,
    output logic              q_memtoreg,
    output logic [DATA_W-1:0] q_read_data,
    output logic [DATA_W-1:0] q_alu,
    output logic [RD_W-1:0]   q_rd
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_regwrite  <= 1'b0;
            q_memtoreg  <= 1'b0;
            q_read_data <= '0;
            q_alu       <= '0;
            q_rd        <= '0;
        end else if (clear) begin
            q_regwrite  <= 1'b0;
            q_memtoreg  <= 1'b0;
        end else if (load) begin
            q_regwrite  <= d_regwrite;
            q_memtoreg  <= d_memtoreg;
            q_read_data <= d_read_data;
            q_alu       <= d_alu;
            q_rd        <= d_rd;
        end
    end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM/WB pipeline register with optional two-entry skid buffer, WB data select,
// forwarding enable and a retired-entry counter.
module mem_wb_pipe_stage
    import mem_wb_pipe_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned RD_W    = DEF_RD_W,
    parameter bit          SKID_EN = 1'b1,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    mem_wb_pipe_stage_if.slave         in_if,
    mem_wb_pipe_stage_if.master        out_if,
    input  logic                       flush,
    output logic [DATA_W-1:0]          wb_data,
    output logic                       fwd_en,
    output logic [CNT_W-1:0]           retire_cnt
);

    occ_e state, state_nxt;
    logic in_ready_q, out_valid_q, in_ready, in_fire, out_fire;
    logic head_load, head_clr, head_from_skid, skid_load, skid_clr, retire;

    logic              h_regwrite, h_memtoreg, s_regwrite, s_memtoreg;
    logic              hd_regwrite, hd_memtoreg;
    logic [DATA_W-1:0] h_read_data, h_alu, s_read_data, s_alu, hd_read_data, hd_alu;
    logic [RD_W-1:0]   h_rd, s_rd, hd_rd;

    // Skid mode breaks the ready path with a register; bypass mode passes it through.
    assign in_ready    = SKID_EN ? in_ready_q : (out_if.ready | ~out_valid_q);
    assign in_if.ready = in_ready;
    assign in_fire     = in_if.valid & in_ready;
    assign out_fire    = out_valid_q & out_if.ready;

    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        head_clr       = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        retire         = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
            head_clr  = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    head_load = 1'b1;
                    state_nxt = ONE;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head_load = 1'b1;
                        retire    = 1'b1;
                    end else if (in_fire && SKID_EN) begin
                        skid_load = 1'b1;
                        state_nxt = TWO;
                    end else if (out_fire) begin
                        head_clr  = 1'b1;
                        retire    = 1'b1;
                        state_nxt = EMPTY;
                    end
                end
                TWO: if (out_fire) begin
                    head_load      = 1'b1;
                    head_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                    retire         = 1'b1;
                    state_nxt      = ONE;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt != TWO);
            out_valid_q <= (state_nxt != EMPTY);
            if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    assign hd_regwrite  = head_from_skid ? s_regwrite  : in_if.regwrite;
    assign hd_memtoreg  = head_from_skid ? s_memtoreg  : in_if.memtoreg;
    assign hd_read_data = head_from_skid ? s_read_data : in_if.read_data;
    assign hd_alu       = head_from_skid ? s_alu       : in_if.alu;
    assign hd_rd        = head_from_skid ? s_rd        : in_if.rd;

    pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) head (
        .clk(clk), .rst(rst), .load(head_load), .clear(head_clr),
        .d_regwrite(hd_regwrite), .d_memtoreg(hd_memtoreg),
        .d_read_data(hd_read_data), .d_alu(hd_alu), .d_rd(hd_rd),
        .q_regwrite(h_regwrite), .q_memtoreg(h_memtoreg),
        .q_read_data(h_read_data), .q_alu(h_alu), .q_rd(h_rd)
    );

    pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) skid (
        .clk(clk), .rst(rst), .load(skid_load), .clear(skid_clr),
        .d_regwrite(in_if.regwrite), .d_memtoreg(in_if.memtoreg),
        .d_read_data(in_if.read_data), .d_alu(in_if.alu), .d_rd(in_if.rd),
        .q_regwrite(s_regwrite), .q_memtoreg(s_memtoreg),
        .q_read_data(s_read_data), .q_alu(s_alu), .q_rd(s_rd)
    );

    assign out_if.valid     = out_valid_q;
    assign out_if.regwrite  = h_regwrite;
    assign out_if.memtoreg  = h_memtoreg;
    assign out_if.read_data = h_read_data;
    assign out_if.alu       = h_alu;
    assign out_if.rd        = h_rd;

    assign wb_data = h_memtoreg ? h_read_data : h_alu;
    assign fwd_en  = out_valid_q & h_regwrite & (h_rd != '0);

endmodule
